// File: rtl/dct_matrix_mac.sv
// Column-serial fixed-point matrix multiply Y[:,j] = C * X[:,j] for the JPEG DCT stage.
// One column in, N multiply-accumulate edges, one rounded/saturated column out.
module dct_matrix_mac #(
    parameter int N  = 8,
    parameter int DW = 12,
    parameter int CW = 16,
    parameter int CF = 14,
    parameter int OW = 16,
    localparam int AD = $clog2(N * N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_col,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*OW-1:0] out_col,
    output logic            out_last,
    input  logic            coef_we,
    input  logic [AD-1:0]   coef_addr,
    input  logic [CW-1:0]   coef_data,
    output logic            coef_err,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = DW + CW;
    localparam int AW = DW + CW + $clog2(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic signed [AW:0] RND  = (AW+1)'(1) <<< (CF - 1);
    localparam logic signed [AW:0] MAXV = (AW+1)'((1 << (OW - 1)) - 1);
    localparam logic signed [AW:0] MINV = -MAXV - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t                state_q;
    logic [KW-1:0]         k_q;
    logic [KW-1:0]         col_cnt_q;
    logic [KW-1:0]         col_idx_q;
    logic signed [DW-1:0]  x_q [N];
    logic signed [AW-1:0]  acc_q [N];
    logic signed [CW-1:0]  coef_mem [N*N];
    logic [N*OW-1:0]       out_col_q;
    logic [N*OW-1:0]       out_col_d;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  coef_err_q;

    logic                  accept;
    logic                  k_last;
    logic                  coef_wr;
    logic signed [DW-1:0]  x_k;
    logic [AD-1:0]         rd_idx [N];
    logic signed [PW-1:0]  prod [N];
    logic signed [AW-1:0]  sum [N];

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid, once raised, holds together with out_col/out_last until that edge.
    assign accept = in_valid && in_ready;
    assign k_last = (k_q == K_LAST);
    assign coef_wr = coef_we && !rst && (state_q == S_IDLE);
    assign x_k = x_q[k_q];

    function automatic logic [OW-1:0] round_sat(input logic signed [AW-1:0] a);
        logic signed [AW:0] r;
        logic [OW-1:0]      res;
        r = ((AW+1)'(a) + RND) >>> CF;
        if (r > MAXV) begin
            res = MAXV[OW-1:0];
        end else if (r < MINV) begin
            res = MINV[OW-1:0];
        end else begin
            res = OW'(r);
        end
        return res;
    endfunction

    // All N rows consume the same sample x[k] each edge, one coefficient column at a time.
    always_comb begin
        out_col_d = '0;
        for (int i = 0; i < N; i++) begin
            rd_idx[i] = AD'(i * N) + AD'(k_q);
            prod[i] = PW'(coef_mem[rd_idx[i]]) * PW'(x_k);
            sum[i] = acc_q[i] + AW'(prod[i]);
            out_col_d[i*OW +: OW] = round_sat(sum[i]);
        end
    end

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE:  in_ready = !coef_we;
                S_OUT:   in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            col_cnt_q   <= '0;
            col_idx_q   <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            coef_err_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                x_q[i]   <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            coef_err_q <= coef_we && (state_q != S_IDLE);
            case (state_q)
                S_ACCUM: begin
                    for (int i = 0; i < N; i++) begin
                        acc_q[i] <= sum[i];
                    end
                    k_q <= k_q + 1'b1;
                    if (k_last) begin
                        out_col_q   <= out_col_d;
                        out_last_q  <= (col_idx_q == K_LAST);
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                end
            endcase
            // An accept in OUT overrides the return to IDLE: the next column starts immediately.
            if (accept) begin
                for (int i = 0; i < N; i++) begin
                    x_q[i]   <= in_col[i*DW +: DW];
                    acc_q[i] <= '0;
                end
                k_q       <= '0;
                col_idx_q <= col_cnt_q;
                col_cnt_q <= (col_cnt_q == K_LAST) ? '0 : col_cnt_q + 1'b1;
                state_q   <= S_ACCUM;
            end
        end
    end

    // The coefficient store has no reset so a loaded matrix survives a datapath reset.
    always_ff @(posedge clk) begin
        if (coef_wr) begin
            coef_mem[coef_addr] <= coef_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign coef_err  = coef_err_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule
